// File: rtl/xaddr_router.sv
// rtl/xaddr_router.sv - address-decoding single-master to N-slave request router
// Optional feature macro: XADDR_TIMEOUT_EN (wait-state timeout with error response)

module xaddr_router #(
    parameter int                      ADDR_W    = 32,
    parameter int                      DATA_W    = 32,
    parameter int                      N_SLV     = 4,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE  = '0,
    parameter logic [N_SLV*8-1:0]      SLV_AW    = '0,
    parameter int                      TIMEOUT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m_valid,
    input  logic [ADDR_W-1:0]       m_addr,
    input  logic                    m_we,
    input  logic [DATA_W-1:0]       m_wdata,
    output logic                    m_ready,
    output logic [DATA_W-1:0]       m_rdata,
    output logic                    m_err,
    output logic [N_SLV-1:0]        s_valid,
    output logic [ADDR_W-1:0]       s_addr,
    output logic                    s_we,
    output logic [DATA_W-1:0]       s_wdata,
    input  logic [N_SLV-1:0]        s_ready,
    input  logic [N_SLV*DATA_W-1:0] s_rdata,
    output logic                    trap
);

    localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    // Reject configurations the select register and timeout counter cannot represent
    if (N_SLV < 1 || N_SLV > 16 || TIMEOUT_W < 1) begin : g_cfg_check
        $error("xaddr_router: N_SLV must be 1..16 and TIMEOUT_W at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   sel_q;

    logic               hit;
    logic [SEL_W-1:0]   hit_idx;
    logic [N_SLV-1:0]   hit_oh;
    logic               sel_ready;
    logic [DATA_W-1:0]  sel_rdata;

    // Mask that keeps only the address bits above a window of 2^aw bytes
    function automatic logic [ADDR_W-1:0] win_mask(input logic [7:0] aw);
        logic [ADDR_W-1:0] m;
        for (int b = 0; b < ADDR_W; b++) begin
            m[b] = (b >= int'(aw));
        end
        return m;
    endfunction

    // Address decode; scanning from the top down lets the lowest matching index win
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_oh  = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((m_addr & win_mask(SLV_AW[i*8 +: 8])) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit        = 1'b1;
                hit_idx    = SEL_W'(i);
                hit_oh     = '0;
                hit_oh[i]  = 1'b1;
            end
        end
    end

    // Only the selected slave's ready and read data are ever looked at
    assign sel_ready = s_ready[sel_q];
    assign sel_rdata = s_rdata[sel_q*DATA_W +: DATA_W];

`ifdef XADDR_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_MAX = {TIMEOUT_W{1'b1}};

    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic [TIMEOUT_W-1:0] tmo_next;

    // The counter value after this WAIT cycle; reaching all-ones ends the wait
    assign tmo_next = tmo_cnt + 1'b1;
`endif

    // Request FSM; every output is a register updated alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            sel_q   <= '0;
            s_valid <= '0;
            s_addr  <= '0;
            s_we    <= 1'b0;
            s_wdata <= '0;
            m_ready <= 1'b0;
            m_rdata <= '0;
            m_err   <= 1'b0;
            trap    <= 1'b0;
`ifdef XADDR_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    m_ready <= 1'b0;
                    trap    <= 1'b0;
                    if (m_valid) begin
                        if (hit) begin
                            s_addr  <= m_addr;
                            s_we    <= m_we;
                            s_wdata <= m_wdata;
                            sel_q   <= hit_idx;
                            s_valid <= hit_oh;
`ifdef XADDR_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                            state   <= ST_WAIT;
                        end else begin
                            // Nobody owns this address: answer with an error straight away
                            m_err   <= 1'b1;
                            m_rdata <= '0;
                            m_ready <= 1'b1;
                            trap    <= 1'b1;
                            state   <= ST_RESP;
                        end
                    end
                end

                ST_WAIT: begin
                    if (sel_ready) begin
                        // A ready on the final count still counts as a clean completion
                        m_rdata <= sel_rdata;
                        m_err   <= 1'b0;
                        m_ready <= 1'b1;
                        s_valid <= '0;
                        state   <= ST_RESP;
                    end
`ifdef XADDR_TIMEOUT_EN
                    else if (tmo_next == TMO_MAX) begin
                        m_err   <= 1'b1;
                        m_rdata <= '0;
                        m_ready <= 1'b1;
                        trap    <= 1'b1;
                        s_valid <= '0;
                        tmo_cnt <= tmo_next;
                        state   <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
`endif
                end

                ST_RESP: begin
                    m_ready <= 1'b0;
                    trap    <= 1'b0;
                    state   <= ST_IDLE;
                end

                default: begin
                    m_ready <= 1'b0;
                    trap    <= 1'b0;
                    s_valid <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
